// File: rtl/digital_clock_pkg.sv
// Shared types and default parameters for the configurable digital clock.
// Mode encoding is also the value presented on the mode output.
package digital_clock_pkg;

    typedef enum logic [1:0] {
        RUN     = 2'd0,
        SET_HR  = 2'd1,
        SET_MIN = 2'd2,
        SET_SEC = 2'd3
    } mode_t;

    localparam int TICK_DIV_DEFAULT  = 50000000;
    localparam int TIMEOUT_S_DEFAULT = 10;

endpackage

// File: rtl/btn_sync_edge.sv
// Two-flop synchroniser followed by a registered rising-edge detector.
// pulse is high for one cycle, three edges after din is first sampled high.
module btn_sync_edge (
    input  logic clk,
    input  logic rst,
    input  logic din,
    output logic pulse
);

    logic sync1_reg;
    logic sync2_reg;
    logic prev_reg;
    logic pulse_reg;

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            sync1_reg <= 1'b0;
            sync2_reg <= 1'b0;
            prev_reg  <= 1'b0;
            pulse_reg <= 1'b0;
        end else begin
            sync1_reg <= din;
            sync2_reg <= sync1_reg;
            prev_reg  <= sync2_reg;
            pulse_reg <= sync2_reg & ~prev_reg;
        end
    end

    assign pulse = pulse_reg;

endmodule

// File: rtl/clock_set_ctrl.sv
// Mode/set controller: 1 Hz prescaler, button pulses, per-field enables, blink.
// Optional SET_TIMEOUT_EN returns to RUN after TIMEOUT_S idle seconds in SET.
module clock_set_ctrl
    import digital_clock_pkg::*;
#(
    parameter int TICK_DIV  = TICK_DIV_DEFAULT,
    parameter int TIMEOUT_S = TIMEOUT_S_DEFAULT
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       btn_mode,
    input  logic       btn_inc,
    input  logic       sec_carry,
    input  logic       min_carry,
    output logic       sec_en,
    output logic       min_en,
    output logic       hr_en,
    output logic [1:0] mode,
    output logic       tick,
    output logic       blink_on
);

    localparam int PW = (TICK_DIV > 1) ? $clog2(TICK_DIV) : 1;
    localparam logic [PW-1:0] PRESC_LAST = PW'(TICK_DIV - 1);
    localparam logic [PW-1:0] PRESC_HALF = PW'(TICK_DIV / 2 - 1);

    logic [PW-1:0] presc_reg;
    logic [PW-1:0] presc_next;
    mode_t         state_reg;
    mode_t         state_next;
    logic          blink_reg;
    logic          blink_next;
    logic          presc_clr;
    logic          timeout_hit;
    logic          mode_p;
    logic          inc_p;

    btn_sync_edge u_mode_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (btn_mode),
        .pulse (mode_p)
    );

    btn_sync_edge u_inc_sync (
        .clk   (clk),
        .rst   (rst),
        .din   (btn_inc),
        .pulse (inc_p)
    );

    assign tick = (presc_reg == PRESC_LAST);

`ifdef SET_TIMEOUT_EN
    localparam int IW = $clog2(TIMEOUT_S + 1);
    localparam logic [IW-1:0] IDLE_LIMIT = IW'(TIMEOUT_S);

    logic [IW-1:0] idle_reg;

    // Any button activity (including the mode press that enters SET_HR) restarts the count.
    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            idle_reg <= '0;
        end else if (state_reg == RUN || mode_p || inc_p) begin
            idle_reg <= '0;
        end else if (tick && idle_reg != IDLE_LIMIT) begin
            idle_reg <= idle_reg + 1'b1;
        end
    end

    assign timeout_hit = (state_reg != RUN) && (idle_reg == IDLE_LIMIT);
`else
    assign timeout_hit = 1'b0;
`endif

    always_comb begin
        state_next = state_reg;
        presc_clr  = 1'b0;
        if (mode_p) begin
            case (state_reg)
                RUN:     state_next = SET_HR;
                SET_HR:  state_next = SET_MIN;
                SET_MIN: state_next = SET_SEC;
                SET_SEC: begin
                    state_next = RUN;
                    presc_clr  = 1'b1;
                end
                default: state_next = RUN;
            endcase
        end else if (timeout_hit) begin
            state_next = RUN;
            presc_clr  = 1'b1;
        end
    end

    // Leaving SET restarts the second so the first one after setting is full length.
    assign presc_next = (presc_clr || tick) ? '0 : presc_reg + 1'b1;

    always_comb begin
        blink_next = blink_reg;
        if (mode_p) begin
            blink_next = 1'b1;
        end else if (presc_reg == PRESC_HALF || tick) begin
            blink_next = ~blink_reg;
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            state_reg <= RUN;
            presc_reg <= '0;
            blink_reg <= 1'b1;
        end else begin
            state_reg <= state_next;
            presc_reg <= presc_next;
            blink_reg <= blink_next;
        end
    end

    // Enables follow the current state, so a tick alongside RUN->SET_HR still counts.
    always_comb begin
        sec_en = 1'b0;
        min_en = 1'b0;
        hr_en  = 1'b0;
        case (state_reg)
            RUN: begin
                sec_en = tick;
                min_en = sec_carry;
                hr_en  = min_carry;
            end
            SET_HR:  hr_en  = inc_p & ~mode_p;
            SET_MIN: min_en = inc_p & ~mode_p;
            SET_SEC: sec_en = inc_p & ~mode_p;
            default: ;
        endcase
    end

    assign mode     = state_reg;
    assign blink_on = (state_reg == RUN) | blink_reg;

endmodule

// File: doc/clock_set_ctrl.md
Name: clock_set_ctrl

Overview:
Mode/set controller for the configurable digital clock. Generates the 1 Hz tick, debounce-free synchronised button pulses, and the per-field enable strobes for the seconds/minutes/hours counter chain. In RUN the enables form a tick/carry cascade. In SET states a button increments only the selected field, with no cascade. Sits between the board buttons and the three counter instances; also drives the display blink control.

Parameters:
TICK_DIV, 50000000, clk cycles per second (even, >= 4)
TIMEOUT_S, 10, seconds of button inactivity before SET auto-exits (used only with SET_TIMEOUT_EN)

Ports:
clk  input  1  system clock, rising edge
rst  input  1  asynchronous active-low reset
btn_mode  input  1  raw mode button, active-high, asynchronous to clk
btn_inc  input  1  raw increment button, active-high, asynchronous to clk
sec_carry  input  1  carry_out of seconds counter
min_carry  input  1  carry_out of minutes counter
sec_en  output  1  seconds counter enable
min_en  output  1  minutes counter enable
hr_en  output  1  hours counter enable
mode  output  2  current state (mode_t encoding)
tick  output  1  1-cycle pulse once per TICK_DIV cycles
blink_on  output  1  selected-field display enable

Behaviour:
- Reset (rst low, async): state RUN, prescaler 0, sync/edge flops 0, blink_phase 1. All outputs are 0 except blink_on = 1 and mode = RUN.
- Prescaler: counts 0..TICK_DIV-1 and wraps. tick = (presc == TICK_DIV-1), decoded from the register. First tick occurs in cycle TICK_DIV-1 after reset release.
- Buttons: 2-flop synchroniser, then rising-edge detect. Pulse mode_p / inc_p is high for exactly 1 cycle, 3 clk edges after raw input is first sampled high. A held button gives one pulse.
- FSM states (mode_t): RUN=0, SET_HR=1, SET_MIN=2, SET_SEC=3.
- Transitions on mode_p: RUN->SET_HR->SET_MIN->SET_SEC->RUN.
- On SET_SEC->RUN, the prescaler is cleared to 0, so the first second after setting is full length.
- mode_p and inc_p in the same cycle: mode_p wins; inc_p is dropped.
- Enables (combinational from registered state/pulses):
  - RUN: sec_en = tick; min_en = sec_carry; hr_en = min_carry.
  - SET_HR: hr_en = inc_p; others 0.
  - SET_MIN: min_en = inc_p; others 0.
  - SET_SEC: sec_en = inc_p; others 0.
  - In SET states the carry inputs are ignored, so minutes wrapping 59->0 does not touch hours.
- Enables use the current state in the cycle mode_p is high. A tick coincident with a RUN->SET_HR mode_p still advances seconds.
- Blink:
  - blink_phase toggles when presc == TICK_DIV/2-1 and when presc == TICK_DIV-1.
  - blink_phase is forced to 1 on every mode_p.
  - blink_on = (state == RUN) | blink_phase.
- Time is frozen in SET states (no tick-driven enables); the prescaler keeps running for blink.
- Reset mid-SET returns to RUN immediately; counters are reset by their own rst.

Optional Feature:
SET_TIMEOUT_EN
- Defined:
  - An idle counter counts ticks while in any SET state.
  - It is cleared by mode_p or inc_p, and on entry to SET_HR.
  - When it reaches TIMEOUT_S, state goes to RUN at the next edge and the prescaler is cleared, as for a normal SET_SEC exit.
  - Idle counter width is $clog2(TIMEOUT_S+1).
- Undefined: no idle counter; SET states persist indefinitely.

Decomposition:
- Package digital_clock_pkg holds:
  - typedef enum logic [1:0] mode_t {RUN, SET_HR, SET_MIN, SET_SEC}
  - localparam defaults for TICK_DIV and TIMEOUT_S
- One sub-module, btn_sync_edge (clk, rst, din -> pulse): 2-flop sync plus edge detect, instanced twice.

Test Plan:
All scenarios use TICK_DIV=10.
1. Reset release, run 35 cycles -> tick high in cycles 9, 19, 29 only; sec_en equals tick; mode = 0.
2. Drive sec_carry=1 with tick, then min_carry=1 -> min_en and hr_en follow in the same cycle; no enables otherwise.
3. Press btn_mode once (held 20 cycles) -> exactly one mode_p, mode = 1; then 2 inc presses -> hr_en pulses twice, sec_en/min_en stay 0.
4. Mode to SET_MIN, assert min_carry and tick -> hr_en stays 0, sec_en stays 0; blink_on toggles every 5 cycles.
5. btn_mode and btn_inc rise in the same cycle while in SET_HR -> mode = 2, no hr_en pulse.
6. SET_TIMEOUT_EN, TIMEOUT_S=3: enter SET_HR, idle -> return to RUN after the 3rd tick; first following tick is 10 cycles later. An inc press at tick 2 restarts the count.
